// File: rtl/plic_reg_arb_pkg.sv
// Shared types, defaults and the round-robin pointer helper for the PLIC
// register-port arbiter.
package plic_reg_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    localparam int unsigned N_MASTER_DEFAULT       = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_intf.sv
// Register-port transaction types (32-bit address, 32-bit data) shared by the
// PLIC register interface and its bus masters.
package reg_intf;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_intf_resp_d32;

endpackage

// File: rtl/plic_rr_pick.sv
// Combinational rotating-priority find-first: returns the first valid index
// at or after ptr, wrapping modulo N_MASTER.
module plic_rr_pick
    import plic_reg_arb_pkg::*;
#(
    parameter int unsigned N_MASTER = N_MASTER_DEFAULT,
    parameter int unsigned IDXW     = $clog2(N_MASTER)
) (
    input  logic [N_MASTER-1:0] valid,
    input  logic [IDXW-1:0]     ptr,
    output logic [IDXW-1:0]     gnt_idx,
    output logic                any_valid
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_idx   = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_MASTER) begin
                idx = idx - N_MASTER;
            end
            if (!any_valid && valid[idx[IDXW-1:0]]) begin
                any_valid = 1'b1;
                gnt_idx   = idx[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/plic_reg_arb.sv
// Round-robin arbiter sharing the PLIC register port between N_MASTER masters.
// Optional busy timeout enabled by defining PLIC_REG_ARB_TIMEOUT_EN.
module plic_reg_arb
    import plic_reg_arb_pkg::*;
#(
    parameter int unsigned N_MASTER       = N_MASTER_DEFAULT,
    parameter int unsigned IDXW           = $clog2(N_MASTER),
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  reg_intf::reg_intf_req_a32_d32 req_i  [N_MASTER],
    output reg_intf::reg_intf_resp_d32    resp_o [N_MASTER],
    output reg_intf::reg_intf_req_a32_d32 req_o,
    input  reg_intf::reg_intf_resp_d32    resp_i,
    output logic                         busy_o
);

    if (N_MASTER < 2) begin : g_bad_n_master
        $error("plic_reg_arb: N_MASTER must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("plic_reg_arb: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e                    state_q, state_d;
    logic [IDXW-1:0]               rr_ptr, winner, gnt_idx;
    logic [N_MASTER-1:0]           valid_vec;
    logic                          any_valid, done, timeout;
    reg_intf::reg_intf_req_a32_d32 req_q;

    for (genvar k = 0; k < N_MASTER; k++) begin : g_valid
        assign valid_vec[k] = req_i[k].valid;
    end

    plic_rr_pick #(
        .N_MASTER (N_MASTER),
        .IDXW     (IDXW)
    ) u_pick (
        .valid     (valid_vec),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .any_valid (any_valid)
    );

`ifdef PLIC_REG_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES);
    logic [CNTW-1:0] busy_cnt;

    // Held at zero while idle, so the first BUSY cycle always sees a count of 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_cnt <= '0;
        end else if (state_q == ARB_IDLE) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + CNTW'(1);
        end
    end

    assign timeout = (state_q == ARB_BUSY) && (busy_cnt == CNTW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign busy_o = (state_q == ARB_BUSY);

    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        resp_o      = '{default: '0};
        req_o       = req_q;
        req_o.valid = req_q.valid & ~timeout;
        if (state_q == ARB_BUSY) begin
            done = resp_i.ready | timeout;
            if (done) begin
                // A real slave answer in the timeout cycle takes precedence.
                resp_o[winner].ready = 1'b1;
                resp_o[winner].error = resp_i.ready ? resp_i.error : 1'b1;
                resp_o[winner].rdata = resp_i.ready ? resp_i.rdata : '0;
                state_d              = ARB_IDLE;
            end
        end else if (any_valid) begin
            state_d = ARB_BUSY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            rr_ptr  <= '0;
            winner  <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && any_valid) begin
                winner <= gnt_idx;
                req_q  <= req_i[gnt_idx];
            end else if (done) begin
                req_q.valid <= 1'b0;
                rr_ptr      <= IDXW'(rr_next(32'(winner), N_MASTER));
            end
        end
    end

endmodule

// File: tb/tb_plic_reg_arb.sv
// Self-checking bench for plic_reg_arb: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction-level model.
module tb_plic_reg_arb;

    localparam int N  = 3;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    reg_intf::reg_intf_req_a32_d32 req    [N];
    reg_intf::reg_intf_resp_d32    resp   [N];
    reg_intf::reg_intf_req_a32_d32 req_o;
    reg_intf::reg_intf_resp_d32    resp_i;
    logic                          busy;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] seen_ready = '0;

    // Transaction-level model: one outstanding grant, its age in BUSY cycles.
    bit                            m_busy = 0;
    int                            m_win  = 0;
    int                            m_ptr  = 0;
    int                            m_age  = 0;
    reg_intf::reg_intf_req_a32_d32 m_lat  = '0;

    always #5 clk = ~clk;

    plic_reg_arb #(
        .N_MASTER       (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .resp_o (resp),
        .req_o  (req_o),
        .resp_i (resp_i),
        .busy_o (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        reg_intf::reg_intf_resp_d32    exp_resp [N];
        reg_intf::reg_intf_req_a32_d32 a_req, e_req;
        bit to_hit, fin;
        int c;
        for (int k = 0; k < N; k++) exp_resp[k] = '0;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_win = 0; m_age = 0;
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_req", 128'(req_o), 128'(0));
            for (int k = 0; k < N; k++) chk($sformatf("rst_resp%0d", k), 128'(resp[k]), 128'(0));
            seen_ready = '0;
        end else begin
            to_hit = 0;
`ifdef PLIC_REG_ARB_TIMEOUT_EN
            to_hit = m_busy && (m_age == TO);
`endif
            fin = m_busy && (resp_i.ready || to_hit);
            if (fin) begin
                exp_resp[m_win].ready = 1'b1;
                exp_resp[m_win].error = resp_i.ready ? resp_i.error : 1'b1;
                exp_resp[m_win].rdata = resp_i.ready ? resp_i.rdata : 32'h0;
            end
            chk("busy", 128'(busy), 128'(m_busy));
            chk("req_valid", 128'(req_o.valid), 128'(m_busy && !to_hit));
            if (m_busy) begin
                a_req = req_o;  a_req.valid = 1'b0;
                e_req = m_lat;  e_req.valid = 1'b0;
                chk("req_fields", 128'(a_req), 128'(e_req));
            end
            for (int k = 0; k < N; k++) begin
                chk($sformatf("resp%0d", k), 128'(resp[k]), 128'(exp_resp[k]));
                seen_ready[k] = resp[k].ready;
            end
            if (m_busy) begin
                if (fin) begin
                    m_busy = 0;
                    m_ptr  = (m_win + 1) % N;
                end else begin
                    m_age++;
                end
            end else begin
                for (int s = 0; s < N; s++) begin
                    c = (m_ptr + s) % N;
                    if (req[c].valid) begin
                        m_busy = 1; m_win = c; m_lat = req[c]; m_age = 1;
                        break;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic v);
        req[k].addr  = a;
        req[k].write = w;
        req[k].wdata = d;
        req[k].wstrb = 4'hF;
        req[k].valid = v;
    endtask

    initial begin
        int order [6];
        order = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < N; k++) req[k] = '0;
        resp_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_busy", 128'(busy), 128'(0));
        chk("lit_rst_req", 128'(req_o), 128'(0));
        rst = 1'b0;

        // Single master-1 write, slave answers in cycle 3
        set_req(1, 32'h0C00_0004, 1'b1, 32'd5, 1'b1);
        tick();
        chk("t1_req", 128'(req_o), 128'({32'h0C00_0004, 1'b1, 32'd5, 4'hF, 1'b1}));
        tick();
        tick();
        resp_i = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        #1;
        chk("t1_resp1", 128'(resp[1]), 128'({32'h0, 1'b0, 1'b1}));
        chk("t1_resp0", 128'(resp[0]), 128'(0));
        chk("t1_resp2", 128'(resp[2]), 128'(0));
        tick();
        req[1].valid = 1'b0;
        resp_i = '0;
        #1;
        chk("t1_idle", 128'(busy), 128'(0));
        // rr_ptr should now be 2: master 2 beats master 0
        set_req(0, 32'h100, 1'b0, 32'h0, 1'b1);
        set_req(2, 32'h200, 1'b0, 32'h0, 1'b1);
        tick();
        chk("t1_ptr2", 128'(req_o.addr), 128'(32'h200));
        resp_i.ready = 1'b1;
        tick();
        req[0].valid = 1'b0;
        req[2].valid = 1'b0;
        resp_i = '0;

        // All masters requesting, slave always ready
        for (int k = 0; k < N; k++) set_req(k, 32'h40 + 32'(16 * k), 1'b1, 32'(k), 1'b1);
        resp_i = '{rdata: 32'h77, error: 1'b0, ready: 1'b1};
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk("t2_busy", 128'(busy), 128'(1));
                chk("t2_order", 128'(req_o.addr), 128'(32'h40 + 32'(16 * order[i / 2])));
                chk("t2_ready", 128'(resp[order[i / 2]].ready), 128'(1));
            end else begin
                chk("t2_bubble", 128'(busy), 128'(0));
            end
            if (i == 11) for (int k = 0; k < N; k++) req[k].valid = 1'b0;
        end
        resp_i = '0;

        // Master 2 read returning 3
        set_req(2, 32'h0C00_0008, 1'b0, 32'h0, 1'b1);
        tick();
        resp_i = '{rdata: 32'h3, error: 1'b0, ready: 1'b1};
        #1;
        chk("t3_resp2", 128'(resp[2]), 128'({32'h3, 1'b0, 1'b1}));
        chk("t3_resp0", 128'(resp[0]), 128'(0));
        chk("t3_resp1", 128'(resp[1]), 128'(0));
        tick();
        req[2].valid = 1'b0;
        resp_i = '0;

        // Master 0 drops valid while BUSY; latched request must persist
        set_req(0, 32'h0C00_0010, 1'b1, 32'hAA, 1'b1);
        tick();
        set_req(0, 32'hDEAD_0000, 1'b0, 32'h55, 1'b0);
        tick();
        chk("t4_held", 128'(req_o), 128'({32'h0C00_0010, 1'b1, 32'hAA, 4'hF, 1'b1}));
        resp_i.ready = 1'b1;
        #1;
        chk("t4_ready0", 128'(resp[0].ready), 128'(1));
        tick();
        resp_i = '0;

        // Reset while BUSY (rr_ptr is 1 beforehand)
        set_req(1, 32'h0C00_0020, 1'b0, 32'h0, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        resp_i.ready = 1'b1;
        #1;
        chk("t5_valid", 128'(req_o.valid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_noready", 128'(resp[1]), 128'(0));
        req[1].valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        resp_i = '0;
        set_req(0, 32'h300, 1'b0, 32'h0, 1'b1);
        set_req(1, 32'h310, 1'b0, 32'h0, 1'b1);
        tick();
        chk("t5_ptr0", 128'(req_o.addr), 128'(32'h300));
        resp_i.ready = 1'b1;
        tick();
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
        resp_i = '0;

`ifdef PLIC_REG_ARB_TIMEOUT_EN
        // Slave silent: forced error completion on the 4th BUSY cycle
        set_req(1, 32'h44, 1'b0, 32'h0, 1'b1);
        resp_i = '{rdata: 32'h1234, error: 1'b0, ready: 1'b0};
        for (int b = 1; b <= TO; b++) begin
            tick();
            if (b < TO) begin
                chk("to_wait", 128'(resp[1].ready), 128'(0));
            end else begin
                chk("to_resp", 128'(resp[1]), 128'({32'h0, 1'b1, 1'b1}));
                chk("to_valid", 128'(req_o.valid), 128'(0));
            end
        end
        tick();
        req[1].valid = 1'b0;
        resp_i.ready = 1'b1;
        #1;
        chk("to_late", 128'(resp[1]), 128'(0));
        tick();
        resp_i = '0;
`endif

        // Randomized traffic; masters hold requests until they see ready
        for (int c = 0; c < 2000; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (req[k].valid && seen_ready[k]) req[k].valid = 1'b0;
                if (!req[k].valid && $urandom_range(0, 2) == 0) begin
                    set_req(k, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b1);
                    req[k].wstrb = 4'($urandom_range(0, 15));
                end
            end
            resp_i.ready = ($urandom_range(0, 4) < 2);
            resp_i.rdata = $urandom;
            resp_i.error = ($urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < N; k++) req[k].valid = 1'b0;
        resp_i = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        repeat (3) tick();
        resp_i = '0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
